// File: rtl/mips_reg_access_ctrl.sv
// mips_sync_fifo: generic single-clock FIFO, head visible combinationally.
// Latency: a pushed entry is at the head the cycle after the push.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
module mips_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_head_dat = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// mips_reg_access_ctrl: operand fetch with write bypass + write-back FIFO for an 8x32 regfile.
// Latency: response 3 cycles after request accept; a write-back commits the cycle after its push.
// Backpressure: req_ready only in IDLE, response held until rsp_ready, wb_ready while FIFO not full. Option: REG0_ZERO_EN.
module mips_reg_access_ctrl #(
  parameter int WB_DEPTH = 2,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rs_data,
  output logic [DATA_W-1:0] rsp_rt_data,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] read_reg_1,
  output logic [ADDR_W-1:0] read_reg_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              signal_reg_write
);
  typedef struct packed {
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] dat;
  } wb_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t            r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_rd1;
  logic [ADDR_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_rs_dat;
  logic [DATA_W-1:0] r_rt_dat;
  logic              r_byp1;
  logic              r_byp2;
  logic [DATA_W-1:0] r_byp1_dat;
  logic [DATA_W-1:0] r_byp2_dat;
  wb_t               r_wb_last;
  wb_t               w_wb_in;
  wb_t               w_head;
  logic              w_wb_push;
  logic              w_full;
  logic              w_empty;
  logic              w_commit;
  logic              w_hit1;
  logic              w_hit2;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

  assign w_wb_in = '{wreg: wb_reg, dat: wb_data};

`ifdef REG0_ZERO_EN
  assign w_wb_push = wb_valid && (wb_reg != '0);
`else
  assign w_wb_push = wb_valid;
`endif

  mips_sync_fifo #(.DEPTH(WB_DEPTH), .WIDTH($bits(wb_t))) u_wb_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_wb_push),
    .i_push_dat (w_wb_in),
    .i_pop      (w_commit),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_commit         = !w_empty;
  assign wb_ready         = !w_full;
  assign signal_reg_write = w_commit;
  assign write_reg        = w_commit ? w_head.wreg : r_wb_last.wreg;
  assign write_data       = w_commit ? w_head.dat  : r_wb_last.dat;

  // Write port keeps showing the last committed write while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst)           r_wb_last <= '0;
    else if (w_commit) r_wb_last <= w_head;
  end

  assign w_hit1 = w_commit && (w_head.wreg == r_rd1);
  assign w_hit2 = w_commit && (w_head.wreg == r_rd2);

  always_comb begin
    w_op1 = read_data_1;
    w_op2 = read_data_2;
    if (r_byp1) w_op1 = r_byp1_dat;
    if (r_byp2) w_op2 = r_byp2_dat;
    if (w_hit1) w_op1 = w_head.dat;
    if (w_hit2) w_op2 = w_head.dat;
`ifdef REG0_ZERO_EN
    if (r_rd1 == '0) w_op1 = '0;
    if (r_rd2 == '0) w_op2 = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_rs_dat    <= '0;
      r_rt_dat    <= '0;
      r_byp1      <= 1'b0;
      r_byp2      <= 1'b0;
      r_byp1_dat  <= '0;
      r_byp2_dat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_rd1       <= req_rs;
          r_rd2       <= req_rt;
          r_req_ready <= 1'b0;
          r_state     <= S_ISSUE;
        end
        // The regfile samples this edge and returns pre-write data, so catch the write here.
        S_ISSUE: begin
          r_byp1  <= w_hit1;
          r_byp2  <= w_hit2;
          if (w_hit1) r_byp1_dat <= w_head.dat;
          if (w_hit2) r_byp2_dat <= w_head.dat;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_rs_dat    <= w_op1;
          r_rt_dat    <= w_op2;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rs_data = r_rs_dat;
  assign rsp_rt_data = r_rt_dat;
  assign read_reg_1  = r_rd1;
  assign read_reg_2  = r_rd2;
endmodule

// File: tb/tb_mips_reg_access_ctrl.sv
// Bench for mips_reg_access_ctrl: regfile environment, queue-based reference model, directed + random traffic.
module tb_mips_reg_access_ctrl;
  localparam int WB_DEPTH = 2;
`ifdef REG0_ZERO_EN
  localparam bit Z0 = 1'b1;
`else
  localparam bit Z0 = 1'b0;
`endif
  localparam logic [31:0] EXP_R0 = Z0 ? 32'h0 : 32'hFFFF_FFFF;

  typedef struct packed { logic [2:0] r; logic [31:0] d; } wr_t;

  logic        clk, rst, req_valid, req_ready, rsp_valid, rsp_ready;
  logic        wb_valid, wb_ready, signal_reg_write;
  logic [2:0]  req_rs, req_rt, wb_reg, read_reg_1, read_reg_2, write_reg;
  logic [31:0] rsp_rs_data, rsp_rt_data, wb_data, read_data_1, read_data_2, write_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit bg_en   = 1'b0;

  mips_reg_access_ctrl #(.WB_DEPTH(WB_DEPTH), .ADDR_W(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_rt(req_rt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rs_data(rsp_rs_data), .rsp_rt_data(rsp_rt_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .write_reg(write_reg), .write_data(write_data), .signal_reg_write(signal_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file environment: registered reads of pre-edge contents, writes commit on the edge.
  logic [31:0] init_rf [8];
  logic [31:0] env_rf  [8];
  bit          env_on = 1'b0;
  always @(posedge clk) begin
    if (!env_on) begin
      for (int i = 0; i < 8; i++) env_rf[i] <= init_rf[i];
      env_on <= 1'b1;
    end else begin
      read_data_1 <= env_rf[read_reg_1];
      read_data_2 <= env_rf[read_reg_2];
      if (signal_reg_write) env_rf[write_reg] <= write_data;
    end
  end

  // Reference model: write queue commits one entry per edge; a response snapshots
  // the architectural registers as they stand after the edge two cycles past accept.
  wr_t         mq[$];
  wr_t         m_w;
  int          m_sz;
  logic [31:0] model_rf [8];
  int          m_phase;
  bit          m_on = 1'b0;
  logic [2:0]  m_rs, m_rt, m_last_r;
  logic [31:0] m_exp_rs, m_exp_rt, m_last_d;

  function automatic logic [31:0] arch_rd(input logic [2:0] r);
    return (Z0 && r == 3'd0) ? 32'h0 : model_rf[r];
  endfunction

  always @(posedge clk) begin
    if (!m_on) for (int i = 0; i < 8; i++) model_rf[i] = init_rf[i];
    m_sz = mq.size();
    if (m_sz > 0) begin
      m_w = mq.pop_front();
      model_rf[m_w.r] = m_w.d;
      m_last_r = m_w.r;
      m_last_d = m_w.d;
    end
    if (rst) begin
      mq.delete();
      m_phase = 0; m_rs = 3'd0; m_rt = 3'd0;
      m_exp_rs = 32'h0; m_exp_rt = 32'h0;
      m_last_r = 3'd0; m_last_d = 32'h0;
      m_on = 1'b1;
    end else begin
      if (wb_valid && m_sz < WB_DEPTH && !(Z0 && wb_reg == 3'd0))
        mq.push_back('{r: wb_reg, d: wb_data});
      if (m_phase == 0) begin
        if (req_valid) begin m_rs = req_rs; m_rt = req_rt; m_phase = 1; end
      end else if (m_phase == 3) begin
        if (rsp_ready) m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
        if (m_phase == 3) begin m_exp_rs = arch_rd(m_rs); m_exp_rt = arch_rd(m_rt); end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    if (!m_on) return;
    chk("req_ready", 32'(req_ready), 32'(m_phase == 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 3));
    if (m_phase == 3) begin
      chk("rsp_rs_data", rsp_rs_data, m_exp_rs);
      chk("rsp_rt_data", rsp_rt_data, m_exp_rt);
    end
    if (m_phase != 0) begin
      chk("read_reg_1", 32'(read_reg_1), 32'(m_rs));
      chk("read_reg_2", 32'(read_reg_2), 32'(m_rt));
    end
    chk("wb_ready", 32'(wb_ready), 32'(mq.size() < WB_DEPTH));
    chk("signal_reg_write", 32'(signal_reg_write), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("write_reg", 32'(write_reg), 32'(mq[0].r));
      chk("write_data", write_data, mq[0].d);
    end else begin
      chk("write_reg_hold", 32'(write_reg), 32'(m_last_r));
      chk("write_data_hold", write_data, m_last_d);
    end
  endtask

  // One cycle: check at negedge, then move inputs just after the next posedge.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    if (bg_en) begin
      wb_valid = 1'($urandom_range(1, 0));
      wb_reg   = 3'($urandom_range(7, 0));
      wb_data  = $urandom;
    end
  endtask

  task automatic drive_wb(input logic [2:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_reg = r; wb_data = d;
  endtask

  // wb_off: cycle (0 = accept cycle) in which to present one write; -1 for none.
  task automatic do_req(input logic [2:0] rs, input logic [2:0] rt, input int wb_off,
                        input logic [2:0] wr, input logic [31:0] wd,
                        input int hold, input bit hold_wr,
                        output logic [31:0] o_rs, output logic [31:0] o_rt, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk("req_ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1; req_rs = rs; req_rt = rt;
    if (wb_off == 0) drive_wb(wr, wd);
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      if (wb_off == lat) drive_wb(wr, wd);
      else if (!bg_en) wb_valid = 1'b0;
      step();
      lat++;
    end
    if (!bg_en) wb_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (hold_wr && h < 3) drive_wb(3'(h + 1), 32'h1000_0000 + 32'(h));
      else if (!bg_en) wb_valid = 1'b0;
      step();
      chk("hold_req_ready", 32'(req_ready), 0);
      if (hold_wr && h < 3) begin
        chk("hold_wr_en", 32'(signal_reg_write), 1);
        chk("hold_wr_reg", 32'(write_reg), h + 1);
        chk("hold_wr_data", write_data, 32'h1000_0000 + 32'(h));
      end
    end
    if (!bg_en) wb_valid = 1'b0;
    o_rs = rsp_rs_data;
    o_rt = rsp_rt_data;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, wd;
    logic [2:0]  wr;
    int          lat;
    rst = 1'b1; req_valid = 1'b0; req_rs = 3'd0; req_rt = 3'd0; rsp_ready = 1'b0;
    wb_valid = 1'b0; wb_reg = 3'd0; wb_data = 32'h0;
    for (int i = 0; i < 8; i++) init_rf[i] = $urandom;
    init_rf[2] = 32'h0000_0011;
    init_rf[5] = 32'h0000_0022;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rs", rsp_rs_data, 0);
    chk("rst_rsp_rt", rsp_rt_data, 0);
    chk("rst_read_reg_1", 32'(read_reg_1), 0);
    chk("rst_read_reg_2", 32'(read_reg_2), 0);
    chk("rst_write_reg", 32'(write_reg), 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_wr_en", 32'(signal_reg_write), 0);
    step();
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_wb_ready", 32'(wb_ready), 1);

    // Plain read, no writes in flight.
    do_req(3'd2, 3'd5, -1, 3'd0, 32'h0, 0, 1'b0, a, b, lat);
    chk("t1_latency", lat, 3);
    chk("t1_rs", a, 32'h0000_0011);
    chk("t1_rt", b, 32'h0000_0022);
    step();
    // Write commits on the ISSUE edge, rs==rt.
    do_req(3'd2, 3'd2, 0, 3'd2, 32'hAAAA_0001, 0, 1'b0, a, b, lat);
    chk("t2_rs", a, 32'hAAAA_0001);
    chk("t2_rt", b, 32'hAAAA_0001);
    step();
    // Write commits on the CAPTURE edge, then one edge too late.
    do_req(3'd3, 3'd5, 1, 3'd5, 32'h0000_BEEF, 0, 1'b0, a, b, lat);
    chk("t3_capture_rt", b, 32'h0000_BEEF);
    step();
    do_req(3'd3, 3'd5, 2, 3'd5, 32'h0000_CAFE, 0, 1'b0, a, b, lat);
    chk("t3_late_rt", b, 32'h0000_BEEF);
    step();
    // Response held four cycles while three writes drain.
    do_req(3'd2, 3'd5, -1, 3'd0, 32'h0, 4, 1'b1, a, b, lat);
    chk("t4_latency", lat, 3);
    chk("t4_rs", a, 32'hAAAA_0001);
    chk("t4_rt", b, 32'h0000_CAFE);
    // Back-to-back write pushes.
    for (int i = 0; i < 10; i++) begin
      wr = 3'($urandom_range(7, 1));
      wd = $urandom;
      drive_wb(wr, wd);
      step();
      chk("burst_wb_ready", 32'(wb_ready), 1);
      chk("burst_wr_en", 32'(signal_reg_write), 1);
      chk("burst_wr_reg", 32'(write_reg), 32'(wr));
      chk("burst_wr_data", write_data, wd);
    end
    wb_valid = 1'b0;
    // Register 0 handling.
    drive_wb(3'd0, 32'hFFFF_FFFF);
    step();
    wb_valid = 1'b0;
    chk("r0_wr_en", 32'(signal_reg_write), 32'(!Z0));
    chk("r0_wb_ready", 32'(wb_ready), 1);
    step();
    do_req(3'd0, 3'd0, -1, 3'd0, 32'h0, 1, 1'b0, a, b, lat);
    chk("r0_rs", a, EXP_R0);
    chk("r0_rt", b, EXP_R0);

    // Random traffic with background write-backs.
    bg_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      do_req(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), -1, 3'd0, 32'h0,
             int'($urandom_range(3, 0)), 1'b0, a, b, lat);
      chk("rand_latency", lat, 3);
      repeat ($urandom_range(2, 0)) step();
    end
    // Reset while a request and writes are in flight.
    req_valid = 1'b1; req_rs = 3'd4; req_rt = 3'd6;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 1);
    for (int k = 0; k < 30; k++) begin
      do_req(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), -1, 3'd0, 32'h0,
             int'($urandom_range(2, 0)), 1'b0, a, b, lat);
      chk("rand2_latency", lat, 3);
    end
    bg_en = 1'b0;
    wb_valid = 1'b0;
    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
